// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel port between three
// tile requesters; each grant is expanded into a clipped 4x4 pixel tile.
module vga_plot_arbiter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour,
  output logic        plot
);

  typedef enum logic {IDLE, DRAW} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] bx_q, bx_d;
  logic [6:0] by_q, by_d;
  logic [2:0] bc_q, bc_d;
  logic [1:0] own_q, own_d;
  logic [1:0] last_q, last_d;

  logic [1:0] p1, p2, win;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_c;

  // Search order after the last owner: last+1, last+2, last (mod 3)
  always_comb begin
    p1 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    if (req[p1])      win = p1;
    else if (req[p2]) win = p2;
    else              win = last_q;
  end

  always_comb begin
    case (win)
      2'd0: begin
        sel_x = req_x[7:0];
        sel_y = req_y[6:0];
        sel_c = req_colour[2:0];
      end
      2'd1: begin
        sel_x = req_x[15:8];
        sel_y = req_y[13:7];
        sel_c = req_colour[5:3];
      end
      default: begin
        sel_x = req_x[23:16];
        sel_y = req_y[20:14];
        sel_c = req_colour[8:6];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bc_d    = bc_q;
    own_d   = own_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          bx_d    = sel_x;
          by_d    = sel_y;
          bc_d    = sel_c;
          own_d   = win;
          cnt_d   = 4'd0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          last_d  = own_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bx_q    <= 8'd0;
      by_q    <= 7'd0;
      bc_q    <= 3'd0;
      own_q   <= 2'd0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bc_q    <= bc_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  logic       draw;
  logic [8:0] xs;
  logic [7:0] ys;
  logic [2:0] oh;

  assign draw = (state_q == DRAW);
  assign xs   = {1'b0, bx_q} + {7'd0, cnt_q[1:0]};
  assign ys   = {1'b0, by_q} + {6'd0, cnt_q[3:2]};
  assign oh   = 3'b001 << own_q;

  assign busy   = draw;
  assign grant  = (draw && cnt_q == 4'd0)  ? oh : 3'b000;
  assign done   = (draw && cnt_q == 4'd15) ? oh : 3'b000;
  assign x_out  = draw ? xs[7:0] : 8'd0;
  assign y_out  = draw ? ys[6:0] : 7'd0;
  assign colour = draw ? bc_q : 3'd0;
  assign plot   = draw && (xs <= 9'(X_MAX)) && (ys <= 8'(Y_MAX));

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized and directed bench for vga_plot_arbiter against a
// tile-level behavioural model of arbitration, drawing and clipping.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant, done;
  logic        busy, plot;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;

  vga_plot_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x),
    .req_y(req_y), .req_colour(req_colour), .grant(grant),
    .done(done), .busy(busy), .x_out(x_out), .y_out(y_out),
    .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one tile in flight, pixel index k walks 0..15 row-major
  bit m_draw = 0;
  int m_k = 0, m_own = 0, m_last = 2;
  int m_bx = 0, m_by = 0, m_bc = 0;
  int c;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_draw = 0; m_k = 0; m_last = 2;
    end else if (m_draw) begin
      if (m_k == 15) begin
        m_draw = 0; m_last = m_own;
      end else m_k = m_k + 1;
    end else if (req != 3'b000) begin
      for (int s = 1; s <= 3; s++) begin
        c = (m_last + s) % 3;
        if (req[c] && !m_draw) begin
          m_draw = 1; m_own = c; m_k = 0;
          m_bx = int'(req_x[8*c +: 8]);
          m_by = int'(req_y[7*c +: 7]);
          m_bc = int'(req_colour[3*c +: 3]);
        end
      end
    end
  end

  always @(negedge clk) begin
    int ex, ey;
    ex = m_bx + m_k % 4;
    ey = m_by + m_k / 4;
    chk("busy", int'(busy), m_draw ? 1 : 0);
    chk("plot", int'(plot), (m_draw && ex <= 159 && ey <= 119) ? 1 : 0);
    chk("x_out", int'(x_out), m_draw ? ex % 256 : 0);
    chk("y_out", int'(y_out), m_draw ? ey % 128 : 0);
    chk("colour", int'(colour), m_draw ? m_bc : 0);
    chk("grant", int'(grant), (m_draw && m_k == 0) ? (1 << m_own) : 0);
    chk("done", int'(done), (m_draw && m_k == 15) ? (1 << m_own) : 0);
  end

  int xs[16], ys[16];
  int plotcnt, g, ng;
  logic [15:0] mask;
  int gv[4], gt[4];

  initial begin
    req = 0; req_x = 0; req_y = 0; req_colour = 0;
    resetn = 1;
    #1 resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_plot", int'(plot), 0);

    // Single request, owner's x changed mid-tile
    @(posedge clk); #1;
    req = 3'b001; req_x[7:0] = 8'd80; req_y[6:0] = 7'd60; req_colour[2:0] = 3'd0;
    @(posedge clk);
    plotcnt = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) begin chk("single_grant", int'(grant), 1); req = 0; end
      if (j == 2) req_x[7:0] = 8'd5;
      xs[j] = int'(x_out); ys[j] = int'(y_out);
      plotcnt += int'(plot);
      if (j == 15) chk("single_done", int'(done), 1);
    end
    chk("single_x5", xs[5], 81);
    chk("single_y5", ys[5], 61);
    chk("single_x15", xs[15], 83);
    chk("single_y15", ys[15], 63);
    chk("single_plots", plotcnt, 16);
    @(negedge clk);
    chk("single_busy_fall", int'(busy), 0);

    // Clipping at the bottom-right corner
    @(posedge clk); #1;
    req = 3'b010; req_x[15:8] = 8'd158; req_y[13:7] = 7'd118; req_colour[5:3] = 3'd1;
    @(posedge clk);
    mask = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("clip_grant", int'(grant), 2);
        chk("clip_colour", int'(colour), 1);
        req = 0;
      end
      mask[j] = plot;
      if (j == 15) chk("clip_done", int'(done), 2);
    end
    chk("clip_mask", int'(mask), 32'h0033);
    @(negedge clk);

    // Hold-off of a request raised mid-tile
    @(posedge clk); #1;
    req = 3'b001; req_x[7:0] = 8'd10; req_y[6:0] = 7'd10;
    @(posedge clk);
    g = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) req = 0;
      else if (grant != 0) g++;
      if (j == 5) begin
        req = 3'b100; req_x[23:16] = 8'd20; req_y[20:14] = 7'd20;
      end
    end
    chk("holdoff_no_grant", g, 0);
    @(negedge clk);
    chk("holdoff_idle_busy", int'(busy), 0);
    chk("holdoff_idle_grant", int'(grant), 0);
    @(negedge clk);
    chk("holdoff_grant", int'(grant), 4);
    req = 0;
    repeat (16) @(negedge clk);

    // Simultaneous requests held continuously
    @(posedge clk); #1;
    req = 3'b111;
    @(posedge clk);
    ng = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (grant != 0 && ng < 4) begin
        gv[ng] = int'(grant); gt[ng] = n; ng++;
        if (ng == 4) req = 0;
      end
    end
    chk("rr_count", ng, 4);
    chk("rr_g0", gv[0], 1);
    chk("rr_g1", gv[1], 2);
    chk("rr_g2", gv[2], 4);
    chk("rr_g3", gv[3], 1);
    chk("rr_gap1", gt[1] - gt[0], 17);
    chk("rr_gap3", gt[3] - gt[2], 17);

    // Reset mid-draw
    @(posedge clk); #1;
    req = 3'b001; req_x[7:0] = 8'd40; req_y[6:0] = 7'd30;
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) req = 0;
    end
    #1 resetn = 0;
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_done", int'(done), 0);
    req = 3'b011;
    @(posedge clk);
    @(negedge clk);
    #1 resetn = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_first_grant", int'(grant), 1);
    req = 3'b010;
    repeat (40) @(negedge clk);
    req = 0;
    repeat (20) @(negedge clk);

    // Random requests with handshake and wandering coordinates
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (m_draw && m_k == 0) req[m_own] = 1'b0;
      for (int i = 0; i < 3; i++)
        if (!req[i] && !(m_draw && m_k == 0 && m_own == i) && $urandom_range(7) == 0)
          req[i] = 1'b1;
      req_x = 24'($urandom);
      req_y = 21'($urandom);
      req_colour = 9'($urandom);
    end
    req = 0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
